xnor_gate: RTL and testbench
============================

Name: xnor_gate

Overview:
- Bitwise 2-input XNOR (equality) primitive for the logic-gate library.
- Primary output `y` is purely combinational.
- A registered copy and a cycle-qualified equality flag are provided for use in clocked datapaths.
- Drop-in usable as a plain gate: the first three declared ports are a, b, y.

Parameters:
- WIDTH, 1, bit width of operands a, b and outputs y, y_q.
- CNT_W, 8, width of the saturating equality-cycle counter eq_cnt.

Ports:
- clk  input  1  rising-edge clock for registered outputs only.
- rst  input  1  asynchronous, active-high reset for registered outputs only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational bitwise XNOR of a and b.
- y_q  output  WIDTH  y registered on clk.
- eq  output  1  combinational; 1 when a == b on all bits (AND-reduction of y).
- eq_q  output  1  eq registered on clk.
- eq_cnt  output  CNT_W  saturating count of clock edges at which eq was 1.

Behaviour:
- Positional declaration order: a, b, y, clk, rst, y_q, eq, eq_q, eq_cnt. A 3-port positional instance (a, b, y) must elaborate and work with the remaining ports unconnected.
- y[i] = ~(a[i] ^ b[i]) for every bit.
  - Zero latency; no dependence on clk or rst.
  - Any change on a or b is reflected on y in the same simulation time step.
- Truth table (WIDTH=1): a=0,b=0 -> y=1; 0,1 -> 0; 1,0 -> 0; 1,1 -> 1.
- eq = &y. Combinational, zero latency, independent of clk and rst.
- Asynchronous reset: when rst = 1, immediately and independent of clk, set y_q = 0, eq_q = 0, eq_cnt = 0. Hold these while rst is high.
- On each rising clk edge with rst = 0:
  - y_q <= y
  - eq_q <= eq
  - if eq = 1 and eq_cnt is not all-ones, eq_cnt <= eq_cnt + 1
  - otherwise eq_cnt holds
- eq_cnt saturates at 2^CNT_W - 1. It never wraps and never decrements. Only rst clears it.
- Reset asserted mid-operation:
  - Registered outputs clear immediately.
  - Combinational y and eq continue to track a and b.
- Reset deassertion: the first rising edge with rst = 0 captures current y and eq normally.
- Operands with X/Z bits: y follows standard Verilog XNOR semantics; no special handling.
- No internal state other than y_q, eq_q, eq_cnt. No handshakes.

Test Plan:
- Exhaustive WIDTH=1 sweep, 5-time-unit steps: (a,b) = (0,0),(0,1),(1,0),(1,1) -> y = 1,0,0,1 and eq = 1,0,0,1, each valid within the same step, with clk idle.
- Registered path: rst pulse, then a=1,b=1 for one clk edge -> y_q=1, eq_q=1, eq_cnt=1. Then a=1,b=0 for one edge -> y_q=0, eq_q=0, eq_cnt stays 1.
- WIDTH=4: a=4'b1010, b=4'b1001 -> y=4'b1100, eq=0. With a=b=4'b0110 -> y=4'b1111, eq=1.
- Saturation with CNT_W=2: hold a=b for 5 edges -> eq_cnt = 1,2,3,3,3.
- Async reset mid-run: with eq_cnt=2, assert rst between clock edges -> eq_cnt, y_q, eq_q go to 0 immediately while y still equals ~(a^b). Deassert rst -> counting resumes from 0 on the next edge.
- Minimal instantiation: connect only a, b, y positionally -> elaborates cleanly and reproduces the truth table.

Source files
------------

// File: rtl/xnor_gate.sv
// Bitwise XNOR gate with a registered copy, a registered equality flag and a
// saturating count of the clock edges at which the operands matched.
module xnor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic             eq,
    output logic             eq_q,
    output logic [CNT_W-1:0] eq_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign y      = ~(a ^ b);
    assign eq     = &y;
    assign eq_cnt = cnt_q;

    // Count matching edges, but stop at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (eq && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            eq_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            y_q   <= y;
            eq_q  <= eq;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xnor_gate.sv
// Directed checks of xnor_gate: truth table, registered path, WIDTH=4,
// counter saturation with CNT_W=2, async reset mid-run and positional hookup.
module tb_xnor_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b1;
    logic       y1, yq1, eq1, eqq1;
    logic [1:0] cnt1;
    logic [3:0] a4 = 4'b0000, b4 = 4'b1111;
    logic [3:0] y4, yq4;
    logic       eq4, eqq4;
    logic [7:0] cnt4;
    logic       pa, pb, py, pyq, peq, peqq;
    logic [7:0] pcnt;

    int errors = 0;
    int checks = 0;

    assign pa = a1;
    assign pb = b1;

    xnor_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
        .a(a1), .b(b1), .y(y1), .clk(clk), .rst(rst),
        .y_q(yq1), .eq(eq1), .eq_q(eqq1), .eq_cnt(cnt1)
    );

    xnor_gate #(.WIDTH(4), .CNT_W(8)) dut4 (
        .a(a4), .b(b4), .y(y4), .clk(clk), .rst(rst),
        .y_q(yq4), .eq(eq4), .eq_q(eqq4), .eq_cnt(cnt4)
    );

    // Positional hookup exercises the declared port order.
    xnor_gate dutp (pa, pb, py, clk, rst, pyq, peq, peqq, pcnt);

    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        a1 = 1'b1; b1 = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({yq1, eqq1, cnt1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dut1: got yq=%b eqq=%b cnt=%0d, want 0 0 0", yq1, eqq1, cnt1);
        end
        checks++;
        if ({yq4, eqq4, cnt4} !== 13'd0) begin
            errors++;
            $display("FAIL reset_dut4: got yq=%b eqq=%b cnt=%0d, want 0000 0 0", yq4, eqq4, cnt4);
        end
        checks++;
        if ({y1, eq1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_comb: got y=%b eq=%b, want 1 1", y1, eq1);
        end
        // Holding reset across an edge must keep everything cleared.
        tick();
        checks++;
        if ({yq1, eqq1, cnt1, pcnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold: got yq=%b eqq=%b cnt=%0d pcnt=%0d, want all 0", yq1, eqq1, cnt1, pcnt);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic       exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            a1 = ab[i][1]; b1 = ab[i][0];
            #5;
            checks++;
            if ({y1, eq1} !== {exp[i], exp[i]}) begin
                errors++;
                $display("FAIL truth_%0d: a=%b b=%b got y=%b eq=%b, want %b %b", i, a1, b1, y1, eq1, exp[i], exp[i]);
            end
            checks++;
            if ({py, peq} !== {exp[i], exp[i]}) begin
                errors++;
                $display("FAIL truth_pos_%0d: got y=%b eq=%b, want %b %b", i, py, peq, exp[i], exp[i]);
            end
        end
    endtask

    task automatic test_registered();
        rst = 1'b1; #1;
        a1 = 1'b0; b1 = 1'b1;
        rst = 1'b0; #1;
        a1 = 1'b1; b1 = 1'b1;
        #1;
        tick();
        checks++;
        if ({yq1, eqq1, cnt1} !== {1'b1, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL reg_match: got yq=%b eqq=%b cnt=%0d, want 1 1 1", yq1, eqq1, cnt1);
        end
        checks++;
        if ({pyq, peqq, pcnt} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL reg_match_pos: got yq=%b eqq=%b cnt=%0d, want 1 1 1", pyq, peqq, pcnt);
        end
        a1 = 1'b1; b1 = 1'b0;
        tick();
        checks++;
        if ({yq1, eqq1, cnt1} !== {1'b0, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL reg_mismatch: got yq=%b eqq=%b cnt=%0d, want 0 0 1", yq1, eqq1, cnt1);
        end
    endtask

    task automatic test_width4();
        a4 = 4'b1010; b4 = 4'b1001;
        #1;
        checks++;
        if ({y4, eq4} !== {4'b1100, 1'b0}) begin
            errors++;
            $display("FAIL w4_diff: got y=%b eq=%b, want 1100 0", y4, eq4);
        end
        tick();
        checks++;
        if ({yq4, eqq4, cnt4} !== {4'b1100, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL w4_diff_reg: got yq=%b eqq=%b cnt=%0d, want 1100 0 0", yq4, eqq4, cnt4);
        end
        a4 = 4'b0110; b4 = 4'b0110;
        #1;
        checks++;
        if ({y4, eq4} !== {4'b1111, 1'b1}) begin
            errors++;
            $display("FAIL w4_same: got y=%b eq=%b, want 1111 1", y4, eq4);
        end
        tick();
        checks++;
        if ({yq4, eqq4, cnt4} !== {4'b1111, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL w4_same_reg: got yq=%b eqq=%b cnt=%0d, want 1111 1 1", yq4, eqq4, cnt4);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        a1 = 1'b0; b1 = 1'b0;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cnt1 !== exp[i]) begin
                errors++;
                $display("FAIL sat_edge_%0d: got cnt=%0d, want %0d", i + 1, cnt1, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        a1 = 1'b1; b1 = 1'b1;
        pulse_reset();
        tick();
        tick();
        checks++;
        if (cnt1 !== 2'd2) begin
            errors++;
            $display("FAIL async_pre: got cnt=%0d, want 2", cnt1);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({yq1, eqq1, cnt1} !== 4'b0000) begin
            errors++;
            $display("FAIL async_clear: got yq=%b eqq=%b cnt=%0d, want 0 0 0", yq1, eqq1, cnt1);
        end
        a1 = 1'b0;
        #1;
        checks++;
        if ({y1, eq1} !== 2'b00) begin
            errors++;
            $display("FAIL async_comb: got y=%b eq=%b, want 0 0", y1, eq1);
        end
        a1 = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        tick();
        checks++;
        if ({yq1, eqq1, cnt1} !== {1'b1, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL async_resume: got yq=%b eqq=%b cnt=%0d, want 1 1 1", yq1, eqq1, cnt1);
        end
    endtask

    initial begin
        test_reset();
        rst = 1'b0;
        #1;
        test_truth_table();
        test_registered();
        test_width4();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
